// File: rtl/and_sched_pkg.sv
// Shared types and defaults for the round-robin AND-unit scheduler.
package and_sched_pkg;

  localparam int unsigned DefNReq  = 4;
  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefLat   = 2;
  localparam int unsigned ID_W     = $clog2(DefNReq);

  typedef struct packed {
    logic              vld;
    logic [ID_W-1:0]   id;
    logic [DefWidth-1:0] data;
  } stage_t;

  // Round-robin pointer advance: one past the granted requester, wrapping at n.
  function automatic logic [ID_W-1:0] rr_next(logic [ID_W-1:0] id, int unsigned n);
    return (id == ID_W'(n - 1)) ? '0 : id + ID_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  gnt_id_o
);

  logic        found;
  int unsigned idx;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(ptr_i) + k) % N_REQ;
      if (en_i && !found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_id_o   = ID_W'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/and_op_scheduler.sv
// Shares one pipelined bitwise-AND unit between N_REQ requesters with round-robin grants.
module and_op_scheduler
  import and_sched_pkg::*;
#(
  // Widths are fixed by and_sched_pkg (stage_t); keep these at the package defaults.
  parameter int unsigned N_REQ = DefNReq,
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned LAT   = DefLat
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   busy
);

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             hs;
  logic [WIDTH-1:0] op_a, op_b;
  stage_t           stage_in;
  stage_t           stage_q [LAT];
  stage_t           stage_d [LAT];

  // Grants are suppressed while reset is held so nothing can be accepted into a cleared pipe.
  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_i    (req_valid),
    .ptr_i    (ptr_q),
    .en_i     (ena & rst_n),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign req_ready = gnt;
  assign hs        = |gnt;
  assign op_a      = req_a[gnt_id*WIDTH +: WIDTH];
  assign op_b      = req_b[gnt_id*WIDTH +: WIDTH];

  always_comb begin
    stage_in.vld  = hs;
    stage_in.id   = gnt_id;
    stage_in.data = op_a & op_b;
  end

  assign ptr_d = hs ? rr_next(gnt_id, N_REQ) : ptr_q;

  // Payload only moves with a valid op, so the output fields hold between pulses.
  always_comb begin
    for (int unsigned k = 0; k < LAT; k++) begin
      stage_d[k] = stage_q[k];
    end
    stage_d[0].vld = stage_in.vld;
    if (stage_in.vld) begin
      stage_d[0].id   = stage_in.id;
      stage_d[0].data = stage_in.data;
    end
    for (int unsigned k = 1; k < LAT; k++) begin
      stage_d[k].vld = stage_q[k-1].vld;
      if (stage_q[k-1].vld) begin
        stage_d[k].id   = stage_q[k-1].id;
        stage_d[k].data = stage_q[k-1].data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      for (int unsigned k = 0; k < LAT; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      for (int unsigned k = 0; k < LAT; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int unsigned k = 0; k < LAT; k++) begin
      busy = busy | stage_q[k].vld;
    end
  end

  assign rsp_valid = stage_q[LAT-1].vld;
  assign rsp_id    = stage_q[LAT-1].id;
  assign rsp_data  = stage_q[LAT-1].data;

endmodule

// File: tb/tb_and_op_scheduler.sv
// Bench for and_op_scheduler: directed tables, corner sequences and a random scoreboard run.
module tb_and_op_scheduler;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           ena;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           busy;

  and_op_scheduler #(
    .N_REQ (N),
    .WIDTH (W),
    .LAT   (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int mptr   = 0;
  int waits [N];

  typedef struct {
    int           due;
    int           id;
    logic [W-1:0] data;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic         en;
    logic [N-1:0] rv;
    logic [N-1:0] rdy;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference grant: first valid requester scanning from the model pointer.
  function automatic int model_grant();
    if (!rst_n || !ena) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(mptr + k) % N]) return (mptr + k) % N;
    end
    return -1;
  endfunction

  task automatic cycle();
    int           g;
    logic [N-1:0] exp_rdy;
    exp_t         e;
    @(negedge clk);
    g       = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("ready", 32'(req_ready), 32'(exp_rdy));
    if (!rst_n) begin
      q.delete();
      mptr = 0;
      for (int i = 0; i < N; i++) waits[i] = 0;
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
    end else begin
      chk("busy", 32'(busy), 32'(q.size() != 0));
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
      end else begin
        chk("rsp_idle", 32'(rsp_valid), 0);
      end
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) waits[i] = 0;
        else if (ena) begin
          if (req_ready[i]) waits[i] = 0;
          else begin
            waits[i]++;
            if (waits[i] > N - 1) chk("fairness", 32'(waits[i]), N - 1);
          end
        end
      end
      if (g >= 0) begin
        e.due  = cyc + LAT;
        e.id   = g;
        e.data = req_a[g*W +: W] & req_b[g*W +: W];
        q.push_back(e);
      end
    end
    @(posedge clk);
    if (rst_n && g >= 0) mptr = (g + 1) % N;
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    ena = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Single op: 0xF0 & 0x3C arrives two cycles after the handshake.
    ena = 1'b1;
    req_valid = 4'b0001;
    req_a[7:0] = 8'hF0;
    req_b[7:0] = 8'h3C;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    cycle();
    req_valid = '0;
    cycle();
    chk("t1_rsp_valid", 32'(rsp_valid), 1);
    chk("t1_rsp_id", 32'(rsp_id), 0);
    chk("t1_rsp_data", 32'(rsp_data), 32'h30);
    cycle();
    cycle();

    // Rotation with all requesters active.
    do_reset();
    ena = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      req_a = {$urandom};
      req_b = {$urandom};
      #1;
      chk("t2_rotate", 32'(req_ready), 32'(1 << (k % N)));
      cycle();
    end
    req_valid = '0;
    repeat (3) cycle();

    // Skip and wrap: move ptr to 3, then only 0 and 2 request.
    do_reset();
    req_valid = 4'b0100;
    cycle();
    req_valid = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_skip", 32'(req_ready), (k == 1) ? 32'h4 : 32'h1);
      chk("t3_no3", 32'(req_ready[3]), 0);
      cycle();
    end
    req_valid = '0;
    repeat (3) cycle();

    // ena drop: accepted ops still drain.
    do_reset();
    req_valid = 4'b0011;
    cycle();
    cycle();
    ena = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("t4_ready_off", 32'(req_ready), 0);
    cycle();
    chk("t4_busy_last", 32'(busy), 1);
    cycle();
    chk("t4_busy_done", 32'(busy), 0);
    cycle();
    req_valid = '0;
    ena = 1'b1;

    // Reset one cycle after a handshake discards the op.
    do_reset();
    req_valid = 4'b0010;
    cycle();
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("t5_busy_now", 32'(busy), 0);
    chk("t5_rsp_now", 32'(rsp_valid), 0);
    cycle();
    cycle();
    rst_n = 1'b1;
    repeat (3) cycle();
    req_valid = 4'b1111;
    #1;
    chk("t5_ptr0", 32'(req_ready), 32'h1);
    cycle();
    req_valid = '0;
    repeat (3) cycle();

    // Table of grant decisions from a fresh reset (ptr starts at 0).
    tbl[0] = '{1'b1, 4'b0001, 4'b0001};
    tbl[1] = '{1'b1, 4'b1111, 4'b0010};
    tbl[2] = '{1'b1, 4'b0101, 4'b0100};
    tbl[3] = '{1'b1, 4'b0101, 4'b0001};
    tbl[4] = '{1'b1, 4'b0000, 4'b0000};
    tbl[5] = '{1'b0, 4'b1111, 4'b0000};
    tbl[6] = '{1'b1, 4'b1000, 4'b1000};
    tbl[7] = '{1'b1, 4'b0110, 4'b0010};
    tbl[8] = '{1'b1, 4'b0011, 4'b0001};
    tbl[9] = '{1'b1, 4'b1100, 4'b0100};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      ena       = tbl[k].en;
      req_valid = tbl[k].rv;
      req_a     = {$urandom};
      req_b     = {$urandom};
      #1;
      chk($sformatf("tbl%0d_ready", k), 32'(req_ready), 32'(tbl[k].rdy));
      cycle();
    end
    ena = 1'b1;
    req_valid = '0;
    repeat (3) cycle();

    // Random traffic against the scoreboard.
    do_reset();
    for (int k = 0; k < 10000; k++) begin
      ena       = ($urandom_range(0, 9) != 0);
      req_valid = N'($urandom);
      req_a     = {$urandom};
      req_b     = {$urandom};
      cycle();
    end
    req_valid = '0;
    repeat (LAT + 2) cycle();
    chk("drain_empty", 32'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
